// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, RV32I width codes
// and the request legality check used at handshake.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } lsu_state_e;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // Misaligned halfword/word, unused width codes, and unsigned stores are all rejected.
    function automatic logic lsu_req_error(
        input logic       we,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic err;
        case (funct3)
            LSU_B, LSU_BU: err = 1'b0;
            LSU_H, LSU_HU: err = addr_lo[0];
            LSU_W:         err = (addr_lo != 2'b00);
            default:       err = 1'b1;
        endcase
        return err || (we && funct3[2]);
    endfunction

    // A store narrower than a word has to read the old word before writing it back.
    function automatic logic lsu_needs_rmw(input logic [2:0] funct3);
        return (funct3 == LSU_B) || (funct3 == LSU_H);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends a load from a memory word and merges
// store data into the addressed byte or halfword lanes of the old word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = mem_word[{byte_off, 3'b000} +: 8];
        half_val = byte_off[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        load_data = '0;
        case (funct3)
            LSU_B:   load_data = {{24{byte_val[7]}}, byte_val};
            LSU_BU:  load_data = {24'b0, byte_val};
            LSU_H:   load_data = {{16{half_val[15]}}, half_val};
            LSU_HU:  load_data = {16'b0, half_val};
            LSU_W:   load_data = mem_word;
            default: load_data = '0;
        endcase
    end

    // Word stores bypass the merge; only byte/halfword stores keep the untouched lanes.
    always_comb begin
        merged_word = mem_word;
        case (funct3)
            LSU_B: merged_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
            LSU_H: begin
                if (byte_off[1]) begin
                    merged_word[31:16] = store_data[15:0];
                end else begin
                    merged_word[15:0] = store_data[15:0];
                end
            end
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only data memory: one request at a time,
// byte/halfword stores done as read-modify-write, one-cycle response pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e      state;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] merged_q;
    logic            err_q;

    logic            req_err;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged_word;

    assign req_err = lsu_req_error(req_we, req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .funct3      (funct3_q),
        .byte_off    (addr_q[1:0]),
        .mem_word    (mem_rdata),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // Request fields are latched only in IDLE, so later input changes cannot disturb
    // an operation in flight; result_q is cleared so stores and errors respond with 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            merged_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        result_q <= '0;
                        err_q    <= req_err;
                        if (req_err) begin
                            state <= RESP;
                        end else if (!req_we) begin
                            state <= LOAD;
                        end else if (lsu_needs_rmw(req_funct3)) begin
                            state <= RMW_RD;
                        end else begin
                            state <= WR;
                        end
                    end
                end
                LOAD: begin
                    result_q <= load_data;
                    state    <= RESP;
                end
                RMW_RD: begin
                    merged_q <= merged_word;
                    state    <= WR;
                end
                WR: begin
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes come straight from the state register, so an asynchronous reset
    // in WR removes mem_write before the next edge can commit the write.
    assign req_ready = (state == IDLE);
    assign mem_read  = (state == LOAD) || (state == RMW_RD);
    assign mem_write = (state == WR);
    assign mem_addr  = (mem_read || mem_write) ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_wdata = mem_write ? (lsu_needs_rmw(funct3_q) ? merged_q : wdata_q) : '0;

    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_valid ? result_q : '0;
    assign rsp_err   = rsp_valid && err_q;

    logic unused_ok;
    assign unused_ok = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic
// checked against a byte-addressed reference memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int compared;
    int mismatched;

    logic [31:0] mem [0:255];
    logic [7:0]  ref_mem [0:1023];
    logic        tb_we;
    logic [7:0]  tb_widx;
    logic [31:0] tb_wval;

    logic [31:0] last_rdata;
    logic        last_err;

    load_store_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory the DUT talks to; the bench can also preload it through its own port.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end else if (tb_we) begin
            mem[tb_widx] <= tb_wval;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic setWord(input logic [31:0] addr, input logic [31:0] w);
        int b;
        b = int'(addr) & 32'h3FC;
        for (int i = 0; i < 4; i++) ref_mem[b + i] = w[8*i +: 8];
        @(negedge clk);
        tb_we = 1'b1;
        tb_widx = addr[9:2];
        tb_wval = w;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    function automatic logic [31:0] refWord(input logic [31:0] addr);
        int b;
        b = int'(addr) & 32'h3FC;
        return {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
    endfunction

    // Reference: natural alignment rule, little-endian byte memory, arithmetic sign extension.
    task automatic modelOp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] exp_rdata,
                           output logic exp_err, output int exp_lat,
                           output logic exp_rd, output logic exp_wr);
        int size;
        int base;
        logic [31:0] val;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        base = int'(addr);
        exp_err = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3[2]) || ((base % size) != 0);
        exp_rdata = '0;
        exp_rd = 1'b0;
        exp_wr = 1'b0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (!we) begin
            exp_lat = 2;
            exp_rd = 1'b1;
            val = '0;
            for (int i = 0; i < size; i++) val = val | (32'(ref_mem[base + i]) << (8 * i));
            if (!f3[2] && size < 4 && val[8*size-1]) val = val - (32'd1 << (8 * size));
            exp_rdata = val;
        end else begin
            exp_lat = (size == 4) ? 2 : 3;
            exp_rd = (size < 4);
            exp_wr = 1'b1;
            for (int i = 0; i < size; i++) ref_mem[base + i] = wdata[8*i +: 8];
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic        exp_rd;
        logic        exp_wr;
        int          lat;
        logic        got;
        logic        saw_rd;
        logic        saw_wr;
        logic        addr_ok;
        modelOp(we, f3, addr, wdata, exp_rdata, exp_err, exp_lat, exp_rd, exp_wr);
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wdata;
        checkOutput("ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        saw_rd = 1'b0;
        saw_wr = 1'b0;
        addr_ok = 1'b1;
        last_rdata = '0;
        last_err = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                req_valid = 1'b0;
                req_we = 1'($urandom);
                req_funct3 = 3'($urandom);
                req_addr = $urandom;
                req_wdata = $urandom;
            end
            if ((mem_read || mem_write) && mem_addr !== {addr[31:2], 2'b00}) addr_ok = 1'b0;
            saw_rd = saw_rd | mem_read;
            saw_wr = saw_wr | mem_write;
            if (rsp_valid) begin
                got = 1'b1;
                last_rdata = rsp_rdata;
                last_err = rsp_err;
            end
        end
        checkOutput("rsp_seen", 32'(got), 32'd1);
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("rsp_rdata", last_rdata, exp_rdata);
        checkOutput("rsp_err", 32'(last_err), 32'(exp_err));
        checkOutput("mem_read_seen", 32'(saw_rd), 32'(exp_rd));
        checkOutput("mem_write_seen", 32'(saw_wr), 32'(exp_wr));
        checkOutput("mem_addr", 32'(addr_ok), 32'd1);
        @(negedge clk);
        checkOutput("rsp_pulse_end", 32'(rsp_valid), 32'd0);
        checkOutput("ready_back", 32'(req_ready), 32'd1);
        checkOutput("mem_word", mem[addr[9:2]], refWord(addr));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared = 0;
        mismatched = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = '0;
        req_addr = '0;
        req_wdata = '0;
        tb_we = 1'b0;
        tb_widx = '0;
        tb_wval = '0;
        last_rdata = '0;
        last_err = 1'b0;

        for (int i = 0; i < 256; i++) setWord(32'(i * 4), $urandom);

        @(negedge clk);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
        checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);

        setWord(32'h40, 32'h8899AABB);
        applyStimulus(1'b0, LSU_B, 32'h41, 32'h0);
        checkOutput("lb_0x41", last_rdata, 32'hFFFFFFAA);
        applyStimulus(1'b0, LSU_BU, 32'h41, 32'h0);
        checkOutput("lbu_0x41", last_rdata, 32'h000000AA);

        applyStimulus(1'b1, LSU_H, 32'h42, 32'h1234);
        checkOutput("sh_word", mem[8'h10], 32'h1234AABB);
        applyStimulus(1'b0, LSU_W, 32'h40, 32'h0);
        checkOutput("lw_after_sh", last_rdata, 32'h1234AABB);

        applyStimulus(1'b0, LSU_W, 32'h46, 32'h0);
        checkOutput("lw_mis_err", 32'(last_err), 32'd1);
        applyStimulus(1'b1, LSU_H, 32'h43, 32'h5555);
        checkOutput("sh_mis_err", 32'(last_err), 32'd1);
        applyStimulus(1'b0, 3'b011, 32'h40, 32'h0);
        checkOutput("f3_011_err", 32'(last_err), 32'd1);

        // Back-to-back: valid held high, second request only taken after RESP.
        begin
            logic [31:0] d0;
            logic        d1;
            int          d2;
            logic        d3;
            logic        d4;
            modelOp(1'b1, LSU_W, 32'h10, 32'hDEADBEEF, d0, d1, d2, d3, d4);
            @(negedge clk);
            req_valid = 1'b1;
            req_we = 1'b1;
            req_funct3 = LSU_W;
            req_addr = 32'h10;
            req_wdata = 32'hDEADBEEF;
            @(posedge clk);
            @(negedge clk);
            checkOutput("b2b_busy_wr", 32'(req_ready), 32'd0);
            req_we = 1'b0;
            req_wdata = 32'h0;
            @(negedge clk);
            checkOutput("b2b_resp1", 32'(rsp_valid), 32'd1);
            checkOutput("b2b_busy_resp", 32'(req_ready), 32'd0);
            @(negedge clk);
            checkOutput("b2b_ready2", 32'(req_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            checkOutput("b2b_busy_ld", 32'(req_ready), 32'd0);
            @(negedge clk);
            checkOutput("b2b_resp2", 32'(rsp_valid), 32'd1);
            checkOutput("b2b_lw_data", rsp_rdata, 32'hDEADBEEF);
            checkOutput("b2b_word", mem[8'h04], refWord(32'h10));
        end

        // Reset in the middle of a byte store's write cycle.
        setWord(32'h20, 32'h0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = LSU_B;
        req_addr = 32'h20;
        req_wdata = 32'hFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("abort_rmw_read", 32'(mem_read), 32'd1);
        @(negedge clk);
        checkOutput("abort_in_wr", 32'(mem_write), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_write_drop", 32'(mem_write), 32'd0);
        checkOutput("abort_wdata_zero", mem_wdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_word_kept", mem[8'h08], 32'h0);
        rst_n = 1'b1;
        checkOutput("abort_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end

        for (int n = 0; n < 60; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            we = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 1023));
            applyStimulus(we, f3, addr, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data and address width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  the single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a memory operation.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 SHALL have port rsp_err  output  1  misaligned or illegal funct3, valid with rsp_valid.
REQ-013 SHALL have ports mem_read, mem_write  output  1 each  strobes to word-only data memory.
REQ-014 SHALL have ports mem_addr, mem_wdata  output  32 each  word address (bits [1:0] = 0) and write word.
REQ-015 SHALL have port mem_rdata  input  32  combinational read word, valid in the cycle mem_read is high.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RMW_RD, WR, RESP.
REQ-017 SHALL drive req_ready = 1 only in IDLE; handshake = req_valid && req_ready.
REQ-018 SHALL latch req_we, req_funct3, req_addr, req_wdata on handshake and ignore request inputs until back in IDLE.
REQ-019 On handshake, SHALL transition: error -> RESP; load -> LOAD; SW -> WR; SB/SH -> RMW_RD.
REQ-020 SHALL flag error for: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 011/110/111; store with funct3[2]=1. An error SHALL produce no memory access.
REQ-021 In LOAD, SHALL assert mem_read and capture the extracted, extended result at cycle end; next state RESP.
REQ-022 In RMW_RD, SHALL assert mem_read and capture the merged word (old word with the addressed byte/halfword lanes replaced from wdata low bits); next state WR.
REQ-023 In WR, SHALL assert mem_write with mem_wdata = merged word (SB/SH) or latched wdata (SW); next state RESP.
REQ-024 In RESP, SHALL assert rsp_valid for exactly one cycle, then return to IDLE; req_ready SHALL stay low during RESP.
REQ-025 Latency from handshake edge to rsp_valid SHALL be: error 1 cycle, LW/LB/LH/LBU/LHU 2, SW 2, SB/SH 3.
REQ-026 Load extraction: byte lane addr[1:0], halfword lane addr[1]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-027 mem_read and mem_write SHALL be decoded from the registered state only, never both high; mem_addr = {addr[31:2],2'b00} while either strobe is high, else 0; mem_wdata = 0 outside WR.
REQ-028 rsp_rdata and rsp_err SHALL hold their values only during RESP and be 0 otherwise.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and drive req_ready=1 once released, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset during WR SHALL deassert mem_write asynchronously, so no write occurs at the next edge. An aborted operation SHALL produce no response.

Structure
REQ-031 SHALL place the FSM state encoding and funct3 constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU) in shared package lsu_pkg.
REQ-032 SHALL place the combinational load extract/extend and store lane merge in sub-module lsu_align.

Verification
REQ-033 Memory word 0x40 = 0x8899AABB. Issue LB at 0x41 -> rsp_rdata 0xFFFFFFAA at 2 cycles. LBU at 0x41 -> 0x000000AA.
REQ-034 Word 0x40 = 0x8899AABB. Issue SH 0x1234 at 0x42 -> mem_read, then mem_write of 0x1234AABB; rsp_valid at 3 cycles; a later LW returns 0x1234AABB.
REQ-035 Issue LW at 0x46 and SH at 0x43 -> rsp_err=1 and rsp_rdata=0 at 1 cycle, with no mem strobes; funct3=011 load -> rsp_err=1.
REQ-036 Hold req_valid high for back-to-back SW 0xDEADBEEF at 0x10, then LW at 0x10 -> the second handshake occurs only after RESP; LW returns 0xDEADBEEF.
REQ-037 Assert rst_n low during WR of SB 0xFF at 0x20 (old word 0) -> mem_write drops immediately, word stays 0, no rsp_valid, and req_ready=1 after release.
